// File: rtl/div_pkg.sv
// Shared types and helpers for the array-divider sequencing controller.
//
// Contents:
//   N_W / D_W / Q_W : dividend, divisor and quotient widths of the array rows
//   SAT_Q           : quotient value reported when the array result is unusable
//   div_state_t     : controller FSM state encoding
//   div_class_t     : {dbz, ovf} screening result for an operand pair
//   div_classify    : screens an operand pair before it is launched into the array
package div_pkg;

  localparam int N_W = 16;
  localparam int D_W = 8;
  localparam int Q_W = 8;

  localparam logic [Q_W-1:0] SAT_Q = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    BYPASS = 2'd2,
    HOLD   = 2'd3
  } div_state_t;

  typedef struct packed {
    logic dbz;
    logic ovf;
  } div_class_t;

  // The true quotient needs more than Q_W bits exactly when the upper half
  // of the dividend is not smaller than the divisor. Divide-by-zero wins, so
  // ovf is never set alongside dbz.
  function automatic div_class_t div_classify(input logic [N_W-1:0] n,
                                              input logic [D_W-1:0] d);
    div_class_t c;
    c.dbz = (d == '0);
    c.ovf = !c.dbz && (n[N_W-1:N_W-D_W] >= d);
    return c;
  endfunction

endpackage

// File: rtl/div_settle_counter.sv
// Settle-time down-counter for the array divider controller.
//
// Ports:
//   clk      : clock
//   rst      : asynchronous active-high reset (counter clears to 0)
//   load     : load load_val this cycle (takes priority over dec)
//   load_val : start value, normally SETTLE_CYCLES-1
//   dec      : decrement by one; ignored when the count is already 0
//   zero     : count is 0 (terminal count)
module div_settle_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/divider_array_ctrl.sv
// Sequential front/back-end for the 16/8 combinational array divider.
//
// Operands are accepted over in_valid/in_ready, registered onto div_n/div_d,
// and left untouched while the array settles. After SETTLE_CYCLES edges the
// array quotient/remainder are captured and offered over out_valid/out_ready.
// Divide-by-zero and quotient-overflow pairs skip the array wait and return a
// saturated, flagged result instead of array garbage.
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_ready : operand handshake; in_n dividend, in_d divisor
//   div_n/div_d       : registered operands driven into the array
//   div_q/div_r       : array quotient/remainder
//   out_valid/out_ready : result handshake
//   out_q/out_r       : result quotient/remainder
//   out_dbz/out_ovf   : divide-by-zero / quotient-overflow flags
//   op_count          : accepted operations, saturating at 16'hFFFF
//
// state  | meaning
// IDLE   | no operation in flight, ready for operands
// SETTLE | operands launched, waiting for the array to settle
// BYPASS | dbz/ovf pair, building the saturated result
// HOLD   | result valid, waiting for the consumer
module divider_array_ctrl
  import div_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N_W-1:0] in_n,
  input  logic [D_W-1:0] in_d,
  output logic [N_W-1:0] div_n,
  output logic [D_W-1:0] div_d,
  input  logic [Q_W-1:0] div_q,
  input  logic [D_W-1:0] div_r,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [Q_W-1:0] out_q,
  output logic [D_W-1:0] out_r,
  output logic           out_dbz,
  output logic           out_ovf,
  output logic [15:0]    op_count
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

  div_state_t state_q;
  div_state_t state_d;

  div_class_t cls_in;
  div_class_t cls_q;

  logic accept;
  logic bypass_in;
  logic cnt_zero;
  logic cnt_load;
  logic cnt_dec;
  logic capture_arr;

  assign cls_in    = div_classify(in_n, in_d);
  assign bypass_in = cls_in.dbz | cls_in.ovf;
  assign accept    = in_valid & in_ready;

  // Only pairs that really go through the array need the settle wait.
  assign cnt_load    = accept & ~bypass_in;
  assign capture_arr = (state_q == SETTLE) & cnt_zero;

  div_settle_counter #(
    .W (CNT_W)
  ) u_settle_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (CNT_INIT),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = bypass_in ? BYPASS : SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_zero) begin
          state_d = HOLD;
        end
      end
      BYPASS: begin
        state_d = HOLD;
      end
      HOLD: begin
        // accept here implies out_ready: retire and relaunch on the same edge
        if (accept) begin
          state_d = bypass_in ? BYPASS : SETTLE;
        end else if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    cnt_dec   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      SETTLE: begin
        cnt_dec = ~cnt_zero;
      end
      HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Operand, result and statistics registers. div_n/div_d change only on an
  // accept, so the array inputs are frozen for the whole settle window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_n    <= '0;
      div_d    <= '0;
      cls_q    <= '0;
      out_q    <= '0;
      out_r    <= '0;
      out_dbz  <= 1'b0;
      out_ovf  <= 1'b0;
      op_count <= '0;
    end else begin
      if (accept) begin
        div_n <= in_n;
        div_d <= in_d;
        cls_q <= cls_in;
        if (op_count != 16'hFFFF) begin
          op_count <= op_count + 16'd1;
        end
      end

      if (capture_arr) begin
        out_q   <= div_q;
        out_r   <= div_r;
        out_dbz <= 1'b0;
        out_ovf <= 1'b0;
      end

      // A zero divisor leaves the whole dividend as remainder; the low byte
      // is what fits the remainder port.
      if (state_q == BYPASS) begin
        out_q   <= SAT_Q;
        out_r   <= cls_q.dbz ? div_n[D_W-1:0] : '0;
        out_dbz <= cls_q.dbz;
        out_ovf <= cls_q.ovf;
      end
    end
  end

endmodule

// File: tb/tb_divider_array_ctrl.sv
module tb_divider_array_ctrl;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_n = '0;
  logic [7:0]  in_d = '0;
  logic [15:0] div_n;
  logic [7:0]  div_d;
  logic [7:0]  div_q;
  logic [7:0]  div_r;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_q;
  logic [7:0]  out_r;
  logic        out_dbz;
  logic        out_ovf;
  logic [15:0] op_count;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  divider_array_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_n      (in_n),
    .in_d      (in_d),
    .div_n     (div_n),
    .div_d     (div_d),
    .div_q     (div_q),
    .div_r     (div_r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_r     (out_r),
    .out_dbz   (out_dbz),
    .out_ovf   (out_ovf),
    .op_count  (op_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Array stand-in: exact division, valid S-1 edges after the operands change.
  function automatic logic [7:0] exact_q(input logic [15:0] n, input logic [7:0] d);
    logic [15:0] q;
    if (d == 0) return 8'hFF;
    q = n / {8'h00, d};
    return q[7:0];
  endfunction

  function automatic logic [7:0] exact_r(input logic [15:0] n, input logic [7:0] d);
    logic [15:0] r;
    if (d == 0) return 8'h00;
    r = n % {8'h00, d};
    return r[7:0];
  endfunction

  logic [7:0] q_pipe [S-1];
  logic [7:0] r_pipe [S-1];

  always @(posedge clk) begin
    q_pipe[0] <= exact_q(div_n, div_d);
    r_pipe[0] <= exact_r(div_n, div_d);
    for (int i = 1; i < S - 1; i++) begin
      q_pipe[i] <= q_pipe[i-1];
      r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign div_q = q_pipe[S-2];
  assign div_r = r_pipe[S-2];

  // Behavioural model: phase 0 idle, 1 computing, 2 result offered.
  int          m_phase;
  int          m_wait;
  bit          m_acc;
  logic [7:0]  m_q, m_r, p_q, p_r;
  bit          m_dbz, m_ovf, p_dbz, p_ovf;
  logic [15:0] m_cnt, m_n;
  logic [7:0]  m_d;

  function automatic bit exp_ready();
    return (m_phase == 0) || (m_phase == 2 && out_ready);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_wait = 0;
      m_q = 0; m_r = 0; m_dbz = 0; m_ovf = 0;
      m_cnt = 0; m_n = 0; m_d = 0;
    end else begin
      m_acc = in_valid && exp_ready();
      if (m_phase == 1) begin
        m_wait--;
        if (m_wait == 0) begin
          m_phase = 2;
          m_q = p_q; m_r = p_r; m_dbz = p_dbz; m_ovf = p_ovf;
        end
      end else if (m_phase == 2 && out_ready) begin
        m_phase = 0;
      end
      if (m_acc) begin
        m_n = in_n; m_d = in_d;
        if (m_cnt != 16'hFFFF) m_cnt++;
        m_phase = 1;
        if (in_d == 0) begin
          p_q = 8'hFF; p_r = in_n[7:0]; p_dbz = 1; p_ovf = 0; m_wait = 1;
        end else if (in_n[15:8] >= in_d) begin
          p_q = 8'hFF; p_r = 8'h00; p_dbz = 0; p_ovf = 1; m_wait = 1;
        end else begin
          p_q = exact_q(in_n, in_d); p_r = exact_r(in_n, in_d);
          p_dbz = 0; p_ovf = 0; m_wait = S;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("m_in_ready", in_ready, exp_ready());
      check("m_out_valid", out_valid, m_phase == 2);
      check("m_out_q", out_q, m_q);
      check("m_out_r", out_r, m_r);
      check("m_out_dbz", out_dbz, m_dbz);
      check("m_out_ovf", out_ovf, m_ovf);
      check("m_op_count", op_count, m_cnt);
      check("m_div_n", div_n, m_n);
      check("m_div_d", div_d, m_d);
    end
  end

  // Called just after a posedge with the block able to accept.
  task automatic send(input logic [15:0] n, input logic [7:0] d, output int lat);
    in_valid = 1; in_n = n; in_d = d;
    @(posedge clk); #1;
    in_valid = 0; in_n = 16'($urandom); in_d = 8'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic expect_res(input string tag, input int lat, input int exp_lat,
                            input logic [7:0] q, input logic [7:0] r,
                            input bit dbz, input bit ovf);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_q"}, out_q, q);
    check({tag, "_r"}, out_r, r);
    check({tag, "_dbz"}, out_dbz, dbz);
    check({tag, "_ovf"}, out_ovf, ovf);
  endtask

  int lat;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_op_count", op_count, 0);
    check("rst_div_n", div_n, 0);
    check("rst_out_q", out_q, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 0;
    @(posedge clk); #1;

    out_ready = 1;
    send(16'd100, 8'd7, lat);
    expect_res("norm_100_7", lat, 3, 8'd14, 8'd2, 0, 0);
    check("norm_count", op_count, 1);
    @(posedge clk); #1;

    send(16'h1234, 8'd0, lat);
    expect_res("dbz", lat, 2, 8'hFF, 8'h34, 1, 0);
    @(posedge clk); #1;

    send(16'h0800, 8'd8, lat);
    expect_res("ovf", lat, 2, 8'hFF, 8'h00, 0, 1);
    @(posedge clk); #1;

    send(16'h07FF, 8'd8, lat);
    expect_res("edge_07ff", lat, 3, 8'd255, 8'd7, 0, 0);
    @(posedge clk); #1;

    out_ready = 0;
    send(16'd200, 8'd9, lat);
    expect_res("bp", lat, 3, 8'd22, 8'd2, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", out_valid, 1);
      check("bp_q", out_q, 22);
      check("bp_r", out_r, 2);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1; in_valid = 1; in_n = 16'd50; in_d = 8'd5;
    #1;
    check("swap_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
    check("swap_valid_drop", out_valid, 0);
    check("swap_q_kept", out_q, 22);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    expect_res("swap", lat, 3, 8'd10, 8'd0, 0, 0);
    check("swap_count", op_count, 6);
    @(posedge clk); #1;

    // Back-to-back accepts with a mix of classes.
    in_valid = 1;
    for (int i = 0; i < 40; i++) begin
      case (i % 4)
        0: begin in_d = 0; in_n = 16'($urandom); end
        1: begin in_d = 8'($urandom_range(1, 255)); in_n = {in_d + 8'($urandom_range(0, 255 - int'(in_d))), 8'($urandom)}; end
        default: begin in_d = 8'($urandom_range(1, 255)); in_n = {8'($urandom_range(0, int'(in_d) - 1)), 8'($urandom)}; end
      endcase
      @(posedge clk); #1;
    end

    // Random handshaking.
    for (int i = 0; i < 1500; i++) begin
      in_valid = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_d = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      in_n = ($urandom_range(0, 3) == 0) ? 16'($urandom) : {8'($urandom_range(0, (in_d == 0) ? 0 : int'(in_d) - 1)), 8'($urandom)};
      @(posedge clk); #1;
    end

    in_valid = 0; out_ready = 1;
    repeat (6) @(posedge clk);
    #1;

    // Reset while settling.
    in_valid = 1; in_n = 16'd100; in_d = 8'd7;
    @(posedge clk); #1;
    in_valid = 0;
    rst = 1;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_count", op_count, 0);
    check("rst_mid_q", out_q, 0);
    check("rst_mid_r", out_r, 0);
    check("rst_mid_div_n", div_n, 0);
    check("rst_mid_div_d", div_d, 0);
    #1;
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("post_rst_valid", out_valid, 0);
      check("post_rst_in_ready", in_ready, 1);
    end

    // Saturation: preload the counter near the top rather than running 65k ops.
    force dut.op_count = 16'hFFFD;
    m_cnt = 16'hFFFD;
    #1;
    release dut.op_count;
    #1;
    send(16'h00AA, 8'd0, lat);
    check("sat_fffe", op_count, 16'hFFFE);
    @(posedge clk); #1;
    send(16'h00AA, 8'd0, lat);
    check("sat_ffff", op_count, 16'hFFFF);
    @(posedge clk); #1;
    send(16'd100, 8'd7, lat);
    check("sat_hold1", op_count, 16'hFFFF);
    @(posedge clk); #1;
    send(16'h0800, 8'd8, lat);
    check("sat_hold2", op_count, 16'hFFFF);
    @(posedge clk); #1;

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
